// File: rtl/decompressor_core.sv
// LZRW1-style streaming decompressor: expands literal/copy items into bytes
// through a history ring, one output byte per cycle behind a valid/ready port.
module decompressor_core #(
  parameter int STRINGSIZE = 4096,
  parameter int HISTSIZE   = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_ctrl,
  input  logic [15:0]                 in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_byte,
  output logic                        out_last,
  output logic [$clog2(STRINGSIZE):0] byte_count,
  output logic                        done,
  output logic                        err
);
  localparam int CW = $clog2(STRINGSIZE) + 1;
  localparam int HW = $clog2(HISTSIZE);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STRINGSIZE);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COPY = 1'b1} state_t;

  // Saturating byte counter step: returns {overflowErr, nextCount}.
  function automatic logic [CW:0] bumpCount(input logic [CW-1:0] cnt);
    if (cnt == COUNT_MAX) begin
      return {1'b1, cnt};
    end else begin
      return {1'b0, cnt + CW'(1)};
    end
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    hist_r [HISTSIZE];
  logic          readyEn_r;
  logic          outValid_r, outValid_s, outLast_r, outLast_s;
  logic [7:0]    outByte_r, outByte_s;
  logic [CW-1:0] byteCount_r, byteCount_s;
  logic          done_r, done_s, err_r, err_s;
  logic [HW-1:0] wrPtr_r, wrPtr_s, src_r, src_s;
  logic [4:0]    remaining_r, remaining_s;
  logic          lastPend_r, lastPend_s, zeroCopy_r, zeroCopy_s, newBlk_r, newBlk_s;

  logic          slotFree_s, outHandshake_s, startNew_s, inReady_s, accept_s, copyErr_s;
  logic [CW-1:0] effCount_s;
  logic          effErr_s;
  logic [HW-1:0] effWr_s;
  logic [11:0]   offset_s;
  logic [7:0]    rdByte_s, histData_s;
  logic [HW-1:0] histAddr_s;
  logic          histWe_s;
  logic [CW:0]   bump_s;

  assign slotFree_s     = !outValid_r || out_ready;
  assign outHandshake_s = outValid_r && out_ready;
  // The item following an in_last item opens a new block, even if accepted
  // in the same cycle as the final byte's handshake.
  assign startNew_s     = newBlk_r || (outHandshake_s && outLast_r);
  assign inReady_s      = readyEn_r && (state_r == ST_IDLE) && slotFree_s;
  assign accept_s       = in_valid && inReady_s;
  assign effCount_s     = startNew_s ? '0 : byteCount_r;
  assign effErr_s       = startNew_s ? 1'b0 : err_r;
  assign effWr_s        = startNew_s ? '0 : wrPtr_r;
  assign offset_s       = in_data[15:4];
  assign rdByte_s       = zeroCopy_r ? 8'h00 : hist_r[src_r];

  assign in_ready   = inReady_s;
  assign out_valid  = outValid_r;
  assign out_byte   = outByte_r;
  assign out_last   = outLast_r;
  assign byte_count = byteCount_r;
  assign done       = done_r;
  assign err        = err_r;

  // Next-state and datapath: output handshake first, then item accept / copy step.
  always_comb begin
    state_s     = state_r;
    outValid_s  = outValid_r;
    outByte_s   = outByte_r;
    outLast_s   = outLast_r;
    byteCount_s = byteCount_r;
    err_s       = err_r;
    wrPtr_s     = wrPtr_r;
    src_s       = src_r;
    remaining_s = remaining_r;
    lastPend_s  = lastPend_r;
    zeroCopy_s  = zeroCopy_r;
    newBlk_s    = newBlk_r;
    done_s      = 1'b0;
    histWe_s    = 1'b0;
    histAddr_s  = wrPtr_r;
    histData_s  = rdByte_s;
    bump_s      = bumpCount(byteCount_r);
    copyErr_s   = 1'b0;

    if (outHandshake_s) begin
      outValid_s = 1'b0;
      outLast_s  = 1'b0;
      done_s     = outLast_r;
      newBlk_s   = newBlk_r || outLast_r;
    end else begin
      outValid_s = outValid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          newBlk_s = 1'b0;
          if (!in_ctrl) begin
            bump_s      = bumpCount(effCount_s);
            outByte_s   = in_data[7:0];
            outValid_s  = 1'b1;
            outLast_s   = in_last;
            byteCount_s = bump_s[CW-1:0];
            err_s       = effErr_s || bump_s[CW];
            histWe_s    = 1'b1;
            histAddr_s  = effWr_s;
            histData_s  = in_data[7:0];
            wrPtr_s     = effWr_s + HW'(1);
          end else begin
            // A bad reference still runs its full length, but emits zeros.
            copyErr_s   = (offset_s == 12'd0) || (32'(offset_s) > 32'(effCount_s));
            byteCount_s = effCount_s;
            err_s       = effErr_s || copyErr_s;
            wrPtr_s     = effWr_s;
            src_s       = effWr_s - HW'(offset_s);
            remaining_s = {1'b0, in_data[3:0]} + 5'd1;
            lastPend_s  = in_last;
            zeroCopy_s  = copyErr_s;
            state_s     = ST_COPY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COPY: begin
        if (slotFree_s) begin
          outByte_s   = rdByte_s;
          outValid_s  = 1'b1;
          outLast_s   = lastPend_r && (remaining_r == 5'd1);
          byteCount_s = bump_s[CW-1:0];
          err_s       = err_r || bump_s[CW];
          histWe_s    = 1'b1;
          wrPtr_s     = wrPtr_r + HW'(1);
          src_s       = src_r + HW'(1);
          remaining_s = remaining_r - 5'd1;
          state_s     = (remaining_r == 5'd1) ? ST_IDLE : ST_COPY;
        end else begin
          state_s = ST_COPY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      readyEn_r   <= 1'b0;
      outValid_r  <= 1'b0;
      outByte_r   <= 8'h00;
      outLast_r   <= 1'b0;
      byteCount_r <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wrPtr_r     <= '0;
      src_r       <= '0;
      remaining_r <= 5'd0;
      lastPend_r  <= 1'b0;
      zeroCopy_r  <= 1'b0;
      newBlk_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      readyEn_r   <= 1'b1;
      outValid_r  <= outValid_s;
      outByte_r   <= outByte_s;
      outLast_r   <= outLast_s;
      byteCount_r <= byteCount_s;
      done_r      <= done_s;
      err_r       <= err_s;
      wrPtr_r     <= wrPtr_s;
      src_r       <= src_s;
      remaining_r <= remaining_s;
      lastPend_r  <= lastPend_s;
      zeroCopy_r  <= zeroCopy_s;
      newBlk_r    <= newBlk_s;
    end
  end

  // History ring write; contents survive reset.
  always_ff @(posedge clock) begin
    if (histWe_s) begin
      hist_r[histAddr_s] <= histData_s;
    end
  end
endmodule

// File: tb/tb_decompressor_core.sv
// Randomized and directed bench for decompressor_core, checked against an
// item-level reference model that expands each item into its byte sequence.
module tb_decompressor_core;
  localparam int STRINGSIZE = 4096;
  localparam int HISTSIZE   = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ctrl = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, done, err;
  logic [7:0]  out_byte;
  logic [12:0] byte_count;

  decompressor_core #(.STRINGSIZE(STRINGSIZE), .HISTSIZE(HISTSIZE)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .byte_count(byte_count), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic ctrl; logic [15:0] data; logic last; } item_t;
  typedef struct packed { logic [7:0] b; logic l; logic [12:0] cnt; logic e; } exp_t;

  item_t      itemQ[$];
  exp_t       expQ[$];
  logic [7:0] mHist [HISTSIZE];
  int         mWr, mCnt;
  bit         mErr, mNew;
  int         total = 0;
  int         bad = 0;
  int         readyMode, gapPct, lowReady, popped, engCycles;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void mEmit(input logic [7:0] b, input bit l);
    mHist[mWr] = b;
    mWr = (mWr + 1) % HISTSIZE;
    if (mCnt == STRINGSIZE) mErr = 1'b1;
    else mCnt++;
    expQ.push_back('{b, l, 13'(mCnt), mErr});
  endfunction

  function automatic void mReset();
    mWr = 0; mCnt = 0; mErr = 1'b0; mNew = 1'b0;
  endfunction

  // Queue an item for the driver and expand it in the model.
  function automatic void pushItem(input bit ctrl, input logic [15:0] data, input bit last);
    int off, n, s;
    bit badOff;
    itemQ.push_back('{ctrl, data, last});
    if (mNew) mReset();
    if (!ctrl) begin
      mEmit(data[7:0], last);
    end else begin
      off = int'(data[15:4]);
      n = int'(data[3:0]) + 1;
      badOff = (off == 0) || (off > mCnt);
      if (badOff) mErr = 1'b1;
      s = (mWr - off + HISTSIZE) % HISTSIZE;
      for (int k = 0; k < n; k++)
        mEmit(badOff ? 8'h00 : mHist[(s + k) % HISTSIZE], last && (k == n - 1));
    end
    if (last) mNew = 1'b1;
  endfunction

  task automatic runEngine(input int stopAt, input int budget);
    bit expDone = 1'b0;
    bit holdPend = 1'b0;
    logic [7:0] held = 8'h00;
    int cyc = 0;
    lowReady = 0;
    popped = 0;
    while (itemQ.size() > 0 || expQ.size() > 0 || expDone) begin
      if (cyc >= budget) begin
        checkVal("timeout", 32'(itemQ.size() + expQ.size() + int'(expDone)), 32'd0);
        break;
      end
      cyc++;
      @(negedge clock);
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 2) == 1);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (itemQ.size() > 0 && ($urandom_range(0, 99) >= gapPct)) begin
        in_valid = 1'b1;
        in_ctrl  = itemQ[0].ctrl;
        in_data  = itemQ[0].data;
        in_last  = itemQ[0].last;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkVal("done", done, expDone);
      expDone = 1'b0;
      if (holdPend) begin
        checkVal("holdValid", out_valid, 1'b1);
        checkVal("holdByte", out_byte, held);
        holdPend = 1'b0;
      end
      if (!in_ready) lowReady++;
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkVal("extraByte", out_valid, 1'b0);
        end else begin
          checkVal("byte", out_byte, expQ[0].b);
          checkVal("last", out_last, expQ[0].l);
          checkVal("count", byte_count, expQ[0].cnt);
          checkVal("err", err, expQ[0].e);
          if (out_ready) begin
            expDone = expQ[0].l;
            void'(expQ.pop_front());
            popped++;
          end else begin
            holdPend = 1'b1;
            held = out_byte;
          end
        end
      end
      if (in_valid && in_ready) void'(itemQ.pop_front());
      if (stopAt > 0 && popped >= stopAt) break;
    end
    in_valid = 1'b0;
    engCycles = cyc;
  endtask

  initial begin
    int eff, off, nItems;
    mReset();
    repeat (3) @(negedge clock);
    #1;
    checkVal("rstValid", out_valid, 1'b0);
    checkVal("rstByte", out_byte, 8'h00);
    checkVal("rstLast", out_last, 1'b0);
    checkVal("rstCount", byte_count, 13'd0);
    checkVal("rstDone", done, 1'b0);
    checkVal("rstErr", err, 1'b0);
    checkVal("rstReady", in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Three literals back to back.
    readyMode = 0; gapPct = 0;
    pushItem(1'b0, 16'h0041, 1'b0);
    pushItem(1'b0, 16'h0042, 1'b0);
    pushItem(1'b0, 16'h0043, 1'b1);
    runEngine(0, 50);
    checkVal("t1Cycles", engCycles, 5);
    checkVal("t1Ready", lowReady, 0);
    checkVal("t1Count", byte_count, 13'd3);

    // Literals then a non-overlapping copy.
    pushItem(1'b0, 16'h0061, 1'b0);
    pushItem(1'b0, 16'h0062, 1'b0);
    pushItem(1'b0, 16'h0063, 1'b0);
    pushItem(1'b1, 16'h0032, 1'b1);
    runEngine(0, 50);
    checkVal("t2Count", byte_count, 13'd6);
    checkVal("t2Err", err, 1'b0);

    // Run-length style overlap: offset 1, sixteen bytes.
    pushItem(1'b0, 16'h0055, 1'b0);
    pushItem(1'b1, 16'h001F, 1'b1);
    runEngine(0, 60);
    checkVal("t3Ready", lowReady, 16);
    checkVal("t3Count", byte_count, 13'd17);

    // Reference beyond the block start, then recovery in the next block.
    pushItem(1'b1, 16'h0050, 1'b1);
    runEngine(0, 20);
    checkVal("t4Err", err, 1'b1);
    pushItem(1'b0, 16'h0099, 1'b1);
    runEngine(0, 20);
    checkVal("t4Count", byte_count, 13'd1);
    checkVal("t4ErrClr", err, 1'b0);

    // Eight-byte copy with the sink toggling.
    readyMode = 1;
    for (int i = 0; i < 4; i++) pushItem(1'b0, 16'(8'hA0 + i), 1'b0);
    pushItem(1'b1, 16'h0047, 1'b1);
    runEngine(0, 80);
    checkVal("t5Count", byte_count, 13'd12);

    // Overrun the block size: count saturates and err rises.
    readyMode = 0;
    pushItem(1'b0, 16'h003C, 1'b0);
    for (int i = 0; i < 256; i++) pushItem(1'b1, 16'h001F, i == 255);
    runEngine(0, 6000);
    checkVal("satCount", byte_count, 13'd4096);
    checkVal("satErr", err, 1'b1);

    // Random blocks with random backpressure and source gaps.
    readyMode = 2; gapPct = 20;
    for (int blk = 0; blk < 40; blk++) begin
      nItems = $urandom_range(1, 12);
      for (int it = 0; it < nItems; it++) begin
        eff = mNew ? 0 : mCnt;
        if (eff == 0 || $urandom_range(0, 1) == 0) begin
          pushItem(1'b0, 16'($urandom_range(0, 255)), it == nItems - 1);
        end else begin
          if ($urandom_range(0, 15) == 0) off = (eff < 4095) ? eff + 1 : 0;
          else off = $urandom_range(1, (eff > 4095) ? 4095 : eff);
          pushItem(1'b1, {off[11:0], 4'($urandom_range(0, 15))}, it == nItems - 1);
        end
      end
    end
    runEngine(0, 20000);

    // Reset in the middle of a ten-byte copy.
    readyMode = 0; gapPct = 0;
    pushItem(1'b0, 16'h0011, 1'b0);
    pushItem(1'b1, 16'h0019, 1'b0);
    runEngine(5, 50);
    #1 reset = 1'b0;
    #1;
    checkVal("midValid", out_valid, 1'b0);
    checkVal("midByte", out_byte, 8'h00);
    checkVal("midLast", out_last, 1'b0);
    checkVal("midCount", byte_count, 13'd0);
    checkVal("midReady", in_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    itemQ.delete();
    expQ.delete();
    mReset();
    pushItem(1'b0, 16'h007E, 1'b1);
    runEngine(0, 20);
    checkVal("postRstCount", byte_count, 13'd1);
    checkVal("postRstErr", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
